sign_mag_adder_arbiter: RTL
===========================

// Module: sign_mag_adder_arbiter
// PURPOSE
//  Shares one rom_sign_mag_adder (4-bit sign-magnitude: bit3 = sign, bits[2:0] = magnitude,
//  registered output, 1-cycle latency) between NUM_REQ requesters.
//  Requesters are served round-robin over valid/ready handshakes.
//  Operands are sequenced into the adder and the result is returned on one response
//  channel, with requester id, overflow flag and a completed-operation counter.
// PARAMETERS
//  NUM_REQ  2   number of requesters, 2..4
//  CNT_W    16  width of op_count
//  ID_W     localparam = (NUM_REQ>2) ? 2 : 1
// PORTS
//  clk        in   1            system clock, rising edge
//  reset      in   1            synchronous, active-high
//  req_valid  in   NUM_REQ      requester i has an operation
//  req_ready  out  NUM_REQ      requester i handshake accepted this cycle
//  req_a      in   4*NUM_REQ    operand A of requester i at [4i+3:4i]
//  req_b      in   4*NUM_REQ    operand B of requester i at [4i+3:4i]
//  rsp_valid  out  1            response available
//  rsp_ready  in   1            consumer accepts response
//  rsp_id     out  ID_W         index of the served requester
//  rsp_sum    out  4            sign-magnitude sum; 0000 on overflow
//  rsp_ovf    out  1            1 = same signs and |a|+|b| > 7
//  op_count   out  CNT_W        responses consumed; saturates at all-ones
// BEHAVIOUR
//  Reset values
//   - FSM in IDLE; rr_ptr = 0.
//   - rsp_valid = 0, req_ready = 0, rsp_id = 0, rsp_ovf = 0, op_count = 0.
//   - Operand registers = 0000.
//   - rsp_sum is don't-care while rsp_valid = 0.
//  FSM states: IDLE -> WAIT -> RESP -> IDLE
//  IDLE
//   - Grant goes to the first i with req_valid[i], searching from rr_ptr upward and wrapping.
//   - req_ready[i] = 1 (combinational) only for the granted i; all other bits are 0.
//   - On handshake: latch a/b into the operand regs (which drive the adder inputs),
//     latch rsp_id and rsp_ovf, set rr_ptr = grant+1 mod NUM_REQ, go to WAIT.
//   - No valid requester: stay in IDLE.
//  WAIT: the adder registers the lookup; unconditionally go to RESP.
//  RESP
//   - rsp_valid = 1; rsp_sum = adder output, combinational.
//   - rsp_sum is stable because the operand regs hold.
//   - Hold until rsp_ready = 1, then go to IDLE and increment op_count (saturating).
//  Timing
//   - Latency: handshake in cycle k -> rsp_valid in cycle k+2.
//   - Minimum spacing between handshakes is 3 cycles.
//  Handshake rules
//   - A requester keeps req_valid and its operands stable until req_ready.
//   - Operands are sampled only at handshake.
//   - rsp_* stay stable while rsp_valid = 1 and rsp_ready = 0.
//  Operand normalisation
//   - Negative zero (1000) on a or b is replaced by 0000 before latching.
//   - The adder never receives 1000.
//  Arithmetic
//   - Overflow: rsp_ovf = sa==sb && ma+mb > 7, computed on the normalised operands with
//     4-bit intermediate (ma+mb).
//   - Opposite signs with equal magnitudes give 0000, rsp_ovf = 0.
//  Reset mid-operation
//   - An in-flight op is dropped with no response; op_count is not incremented.
//   - The next grant restarts from requester 0.
//  Simultaneous events
//   - A request arriving while in WAIT or RESP is not granted; req_ready stays 0 until IDLE.
//   - rsp_ready while rsp_valid = 0 is ignored.
// STRUCTURE
//  Shared package sm_adder_pkg
//   - localparams SM_W = 4, SM_MAG_W = 3, SM_NEG_ZERO = 4'b1000.
//   - FSM state encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
//  Sub-modules
//   - One instance of rom_sign_mag_adder (clk, a, b, data), used unmodified.
//   - Round-robin priority pick stays inline; no further sub-module.
// TESTING
//  1. Reset held 3 cycles, no requests -> rsp_valid=0, req_ready=0, op_count=0.
//  2. Req0 a=0011 b=0010, rsp_ready=1 -> req_ready[0] at k; rsp_valid at k+2 with
//     sum=0101, id=0, ovf=0; op_count=1.
//  3. Req1 a=1011 b=0101 -> sum=0010, ovf=0, id=1.
//     Req0 a=0110 b=0101 -> sum=0000, ovf=1.
//     Req0 a=1111 b=1111 -> sum=0000, ovf=1.
//  4. Both requesters valid for 4 ops, rsp_ready=1 -> grant order 0,1,0,1.
//     Handshakes spaced exactly 3 cycles apart; ids match.
//  5. a=1000 b=0011 -> sum=0011, ovf=0.
//     rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, no new req_ready, op_count unchanged.
//  6. Reset asserted in WAIT -> next cycle IDLE with rsp_valid=0.
//     Both requesters valid -> requester 0 granted first; op_count unchanged by the dropped op.

Source files
------------

// File: rtl/sm_adder_pkg.sv
// rtl/sm_adder_pkg.sv - shared sign-magnitude constants, FSM encoding and helpers
// Purpose: constants and types shared by the sign-magnitude adder arbiter slice.
// Ports: none (package).
package sm_adder_pkg;

  localparam int SM_W     = 4;
  localparam int SM_MAG_W = 3;
  localparam logic [SM_W-1:0] SM_NEG_ZERO = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sm_state_e;

  // Negative zero is folded to positive zero so the adder only ever sees one zero.
  function automatic logic [SM_W-1:0] sm_normalise(input logic [SM_W-1:0] v);
    return (v == SM_NEG_ZERO) ? '0 : v;
  endfunction

endpackage

// File: rtl/rom_sign_mag_adder.sv
// rtl/rom_sign_mag_adder.sv - 4-bit sign-magnitude adder lookup with registered output
// Purpose: registered sign-magnitude sum of a and b (1-cycle latency); overflow yields 0000.
// Ports:
//   clk   in  1  rising-edge clock
//   a     in  4  operand A, bit3 = sign, bits[2:0] = magnitude
//   b     in  4  operand B, same encoding
//   data  out 4  registered sum, updated every cycle from a/b
module rom_sign_mag_adder (
  input  logic       clk,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] data
);

  // Table contents expressed as the function the ROM encodes.
  function automatic logic [3:0] sm_lookup(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] tot;
    logic [2:0] mag;
    logic       sgn;
    tot = {1'b0, x[2:0]} + {1'b0, y[2:0]};
    if (x[3] == y[3]) begin
      sgn = x[3];
      mag = tot[3] ? 3'd0 : tot[2:0];
      if (tot[3]) sgn = 1'b0;
    end else if (x[2:0] >= y[2:0]) begin
      sgn = x[3];
      mag = x[2:0] - y[2:0];
    end else begin
      sgn = y[3];
      mag = y[2:0] - x[2:0];
    end
    // A zero magnitude is always reported as positive zero.
    if (mag == 3'd0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  always_ff @(posedge clk) begin
    data <= sm_lookup(a, b);
  end

endmodule

// File: rtl/sign_mag_adder_arbiter.sv
// rtl/sign_mag_adder_arbiter.sv - round-robin arbiter sharing one sign-magnitude adder
// Purpose: serves NUM_REQ requesters round-robin, sequences operands through one
//          registered sign-magnitude adder and returns sum/id/overflow on a response channel.
// Ports:
//   clk        in  1          rising-edge clock
//   reset      in  1          synchronous, active-high
//   req_valid  in  NUM_REQ    requester i has an operation
//   req_ready  out NUM_REQ    handshake accepted for requester i this cycle
//   req_a      in  4*NUM_REQ  operand A of requester i at [4i+3:4i]
//   req_b      in  4*NUM_REQ  operand B of requester i at [4i+3:4i]
//   rsp_valid  out 1          response available
//   rsp_ready  in  1          consumer accepts response
//   rsp_id     out ID_W       index of the served requester
//   rsp_sum    out 4          sign-magnitude sum, 0000 on overflow
//   rsp_ovf    out 1          same signs and |a|+|b| > 7
//   op_count   out CNT_W      responses consumed, saturating
module sign_mag_adder_arbiter
  import sm_adder_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = (NUM_REQ > 2) ? 2 : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [SM_W-1:0]      rsp_sum,
  output logic                 rsp_ovf,
  output logic [CNT_W-1:0]     op_count
);

  sm_state_e       state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx, hi_idx, lo_idx;
  logic            found_hi, found_lo;
  logic [SM_W-1:0] grant_a, grant_b, norm_a, norm_b;
  logic [SM_W-1:0] op_a, op_b, adder_sum;
  logic [SM_W-1:0] mag_sum;
  logic            grant_ovf;
  logic            hs, rsp_fire;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
  // (the wrap-around). Descending loop so the last hit is the lowest index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found_lo = 1'b1;
        lo_idx   = ID_W'(i);
        if (i >= int'(rr_ptr)) begin
          found_hi = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_idx = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_a   = '0;
    grant_b   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_a      = req_a[4*i +: 4];
        grant_b      = req_b[4*i +: 4];
        req_ready[i] = (state == IDLE) && found_lo;
      end
    end
  end

  assign norm_a    = sm_normalise(grant_a);
  assign norm_b    = sm_normalise(grant_b);
  // Overflow decided on normalised operands with a 4-bit magnitude sum.
  assign mag_sum   = {1'b0, norm_a[SM_MAG_W-1:0]} + {1'b0, norm_b[SM_MAG_W-1:0]};
  assign grant_ovf = (norm_a[SM_W-1] == norm_b[SM_W-1]) && (mag_sum > 4'd7);

  assign hs        = (state == IDLE) && found_lo;
  assign rsp_fire  = (state == RESP) && rsp_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found_lo) state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_a    <= norm_a;
        op_b    <= norm_b;
        rsp_id  <= grant_idx;
        rsp_ovf <= grant_ovf;
        rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (rsp_fire && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

  // Operand registers hold through WAIT and RESP, so the adder output is stable in RESP.
  rom_sign_mag_adder u_adder (
    .clk  (clk),
    .a    (op_a),
    .b    (op_b),
    .data (adder_sum)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_sum   = adder_sum;

endmodule
